pkt_serial_tx: RTL and testbench
================================

Name: pkt_serial_tx

Overview:
- Transmit side of the my_packet_t link: accepts read/write/error commands over a valid/ready handshake and builds a 12-bit my_packet_t {id[3:0], data[7:0]}.
- Serializes the packet MSB-first on a framed 1-bit line.
- Feeds the receive path, where packets are classified by id/data (A = read, B = write, C with data 5 = error).
- FSM state uses the shared fsm_state_e encoding.

Parameters:
- GAP_CYCLES, 1, idle cycles after the last bit of a frame before in_ready reasserts; legal range 0..15.
- ERR_DATA, 8'd5, data byte carried in error packets.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  command valid
- in_ready  output  1  block can accept a command
- in_cmd  input  2  2'b01 read, 2'b10 write, 2'b00/2'b11 illegal (error packet)
- in_data  input  8  payload for read/write
- tx_frame  output  1  high while a packet bit is driven
- tx_bit  output  1  serial packet bit, MSB (id[3]) first
- out_state  output  fsm_state_e  current FSM state
- err_count  output  8  count of illegal commands, saturating

Behaviour:
- Reset values (one clk edge with rst=1):
  - state STATE_IDLE; in_ready=1; tx_frame=0; tx_bit=0; err_count=0.
  - Shift register, bit counter and gap counter all 0.
- Reset mid-frame: frame aborted; tx_frame low from the cycle after the reset edge; no partial resume.
- Handshake:
  - Accept on a clk edge with in_valid && in_ready.
  - in_ready=1 only in STATE_IDLE with gap counter 0. It is registered, not combinational on in_valid.
  - in_cmd/in_data are sampled only at acceptance; they may change freely afterwards.
- Packet build at acceptance:
  - read: {4'hA, in_data}
  - write: {4'hB, in_data}
  - illegal: {4'hC, ERR_DATA}; in_data is ignored.
- FSM transitions:
  - IDLE -> READ / WRITE / ERROR on acceptance, by command.
  - READ/WRITE/ERROR -> IDLE after the 12th bit.
  - No other transitions.
- Timing, for acceptance at edge N:
  - tx_frame=1 in cycles N+1..N+12; tx_bit = packet[11], packet[10], ..., packet[0] in those cycles.
  - tx_frame=0 from cycle N+13.
  - in_ready=0 for cycles N+1..N+12+GAP_CYCLES; in_ready=1 at cycle N+13+GAP_CYCLES.
  - With GAP_CYCLES=0, frames can be 13 cycles apart (one idle cycle minimum).
- tx_bit when tx_frame=0: driven 0.
- err_count:
  - Increments at acceptance of an illegal command.
  - Saturates at 8'hFF, with no wrap.
  - Unaffected by legal commands.
- out_state is the registered state, visible the cycle after each transition edge.
- in_valid while in_ready=0: ignored, no side effects. The sender holds it.
- Gap counter counts down once per cycle from GAP_CYCLES, loaded on the cycle the last bit is sent.

Decomposition:
- Shared package holds:
  - my_packet_t and fsm_state_e (reused, not redefined).
  - Constants: ID_READ=4'hA, ID_WRITE=4'hB, ID_ERROR=4'hC, CMD_READ=2'b01, CMD_WRITE=2'b10, PKT_W=12.
- One sub-module, pkt_shift_out: a loadable 12-bit MSB-first shifter with a bit counter and a done pulse.
- The top level holds the FSM, handshake, gap counter and error counter.

Test Plan:
- Reset then read, in_cmd=01, in_data=8'h3C:
  - out_state=STATE_READ.
  - Bits over 12 framed cycles: 1010_0011_1100.
  - in_ready back at N+14 (GAP_CYCLES=1).
- Write, in_data=8'hFF: serial 1011_1111_1111; out_state=STATE_WRITE; err_count stays 0.
- Illegal in_cmd=11, in_data=8'h77:
  - Serial 1100_0000_0101 (data forced to 5).
  - out_state=STATE_ERROR; err_count=1.
- 256 illegal commands back-to-back: err_count reaches 8'hFF and stays 8'hFF; every frame is still id C, data 5.
- in_valid held high throughout with GAP_CYCLES=0:
  - Acceptances exactly 13 cycles apart.
  - No command accepted while tx_frame=1.
- rst asserted at bit 6 of a write frame:
  - tx_frame=0, in_ready=1, out_state=STATE_IDLE from the next cycle.
  - err_count=0.
  - A following read transmits a clean 12-bit frame.

Source files
------------

// File: rtl/pkt_serial_tx_pkg.sv
// Shared types and constants for the my_packet_t serial link.
// Imported by the transmitter, its shifter and the bench.
package pkt_serial_tx_pkg;

    localparam int PKT_W = 12;

    localparam logic [3:0] ID_READ  = 4'hA;
    localparam logic [3:0] ID_WRITE = 4'hB;
    localparam logic [3:0] ID_ERROR = 4'hC;

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] data;
    } my_packet_t;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_READ  = 2'd1,
        STATE_WRITE = 2'd2,
        STATE_ERROR = 2'd3
    } fsm_state_e;

    // Illegal commands carry a fixed error payload, not the caller's data.
    function automatic my_packet_t build_pkt(
        input logic [1:0] cmd,
        input logic [7:0] data,
        input logic [7:0] err_data
    );
        my_packet_t p;
        unique case (cmd)
            CMD_READ:  p = '{id: ID_READ,  data: data};
            CMD_WRITE: p = '{id: ID_WRITE, data: data};
            default:   p = '{id: ID_ERROR, data: err_data};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/pkt_shift_out.sv
// Loadable MSB-first packet shifter with bit counter and done pulse.
// done_o is high during the cycle the last bit is on the line.
module pkt_shift_out
    import pkt_serial_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  my_packet_t pkt_i,
    output logic       bit_o,
    output logic       frame_o,
    output logic       done_o
);

    logic [PKT_W-1:0] shreg_q, shreg_d;
    logic [3:0]       cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = pkt_i;
            cnt_d   = 4'(PKT_W);
        end else if (cnt_q != 4'd0) begin
            shreg_d = {shreg_q[PKT_W-2:0], 1'b0};
            cnt_d   = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign frame_o = (cnt_q != 4'd0);
    assign bit_o   = frame_o & shreg_q[PKT_W-1];
    assign done_o  = (cnt_q == 4'd1);

endmodule

// File: rtl/pkt_serial_tx.sv
// Transmit side of the my_packet_t link: command handshake, packet
// build, framed serial output, inter-frame gap and error counter.
module pkt_serial_tx
    import pkt_serial_tx_pkg::*;
#(
    parameter int         GAP_CYCLES = 1,
    parameter logic [7:0] ERR_DATA   = 8'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_cmd,
    input  logic [7:0] in_data,
    output logic       tx_frame,
    output logic       tx_bit,
    output fsm_state_e out_state,
    output logic [7:0] err_count
);

    fsm_state_e state_q, state_d;
    logic [3:0] gap_q, gap_d;
    logic [7:0] err_q, err_d;
    logic       accept;
    logic       done;
    my_packet_t pkt;

    assign in_ready = (state_q == STATE_IDLE) && (gap_q == 4'd0);
    assign accept   = in_valid && in_ready;
    assign pkt      = build_pkt(in_cmd, in_data, ERR_DATA);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STATE_IDLE: begin
                if (accept) begin
                    unique case (in_cmd)
                        CMD_READ:  state_d = STATE_READ;
                        CMD_WRITE: state_d = STATE_WRITE;
                        default:   state_d = STATE_ERROR;
                    endcase
                end
            end
            STATE_READ, STATE_WRITE, STATE_ERROR: begin
                if (done) state_d = STATE_IDLE;
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    // Gap loads as the last bit leaves so in_ready waits GAP_CYCLES more.
    always_comb begin
        gap_d = gap_q;
        if (done) begin
            gap_d = 4'(GAP_CYCLES);
        end else if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end
    end

    always_comb begin
        err_d = err_q;
        if (accept && pkt.id == ID_ERROR && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_IDLE;
            gap_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
        end
    end

    pkt_shift_out u_shift (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .pkt_i   (pkt),
        .bit_o   (tx_bit),
        .frame_o (tx_frame),
        .done_o  (done)
    );

    assign out_state = state_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_pkt_serial_tx.sv
// Directed bench for pkt_serial_tx: GAP_CYCLES=1 main instance plus
// a GAP_CYCLES=0 instance for back-to-back spacing.
module tb_pkt_serial_tx;
    import pkt_serial_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, tx_frame, tx_bit;
    logic [1:0] in_cmd;
    logic [7:0] in_data, err_count;
    fsm_state_e out_state;

    logic       v0, r0, f0, b0;
    logic [1:0] c0;
    logic [7:0] d0, e0;
    fsm_state_e s0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    pkt_serial_tx #(.GAP_CYCLES(1), .ERR_DATA(8'd5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cmd(in_cmd), .in_data(in_data),
        .tx_frame(tx_frame), .tx_bit(tx_bit),
        .out_state(out_state), .err_count(err_count)
    );

    pkt_serial_tx #(.GAP_CYCLES(0), .ERR_DATA(8'd5)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(v0), .in_ready(r0),
        .in_cmd(c0), .in_data(d0),
        .tx_frame(f0), .tx_bit(b0),
        .out_state(s0), .err_count(e0)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one command, capture its 12 framed bits, check gap/ready.
    task automatic send(input logic [1:0] cmd, input logic [7:0] data,
                        input logic hold, input fsm_state_e st,
                        input logic [11:0] exp_pkt, input string tag);
        int w;
        logic [11:0] got;
        logic fr_ok;
        w = 0;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_cmd   = cmd;
        in_data  = data;
        tick();
        in_valid = hold;
        in_cmd   = 2'b11;
        in_data  = ~data;
        check({tag, "_st"}, 32'(out_state), 32'(st));
        fr_ok = 1'b1;
        got   = '0;
        for (int i = 0; i < 12; i++) begin
            fr_ok = fr_ok & tx_frame & ~in_ready;
            got[11-i] = tx_bit;
            tick();
        end
        in_valid = 1'b0;
        check({tag, "_pkt"}, 32'(got), 32'(exp_pkt));
        check({tag, "_frm"}, 32'(fr_ok), 32'd1);
        check({tag, "_end"}, {29'd0, tx_frame, in_ready, tx_bit}, 32'd0);
        tick();
        check({tag, "_rdy14"}, 32'(in_ready), 32'd1);
        check({tag, "_idle"}, 32'(out_state), 32'(STATE_IDLE));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last, nacc, bad;
        logic [11:0] got;
        rst = 1'b1;
        in_valid = 1'b0; in_cmd = 2'b00; in_data = 8'h00;
        v0 = 1'b0; c0 = CMD_READ; d0 = 8'h3C;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_frame", 32'(tx_frame), 32'd0);
        check("rst_bit", 32'(tx_bit), 32'd0);
        check("rst_state", 32'(out_state), 32'(STATE_IDLE));
        check("rst_err", 32'(err_count), 32'd0);

        send(2'b01, 8'h3C, 1'b0, STATE_READ, 12'hA3C, "read");
        check("read_err", 32'(err_count), 32'd0);
        send(2'b10, 8'hFF, 1'b1, STATE_WRITE, 12'hBFF, "write");
        check("write_err", 32'(err_count), 32'd0);
        send(2'b11, 8'h77, 1'b0, STATE_ERROR, 12'hC05, "illegal");
        check("illegal_err", 32'(err_count), 32'd1);
        send(2'b00, 8'h12, 1'b0, STATE_ERROR, 12'hC05, "illegal00");
        check("illegal00_err", 32'(err_count), 32'd2);

        for (int k = 0; k < 252; k++)
            send(2'b11, 8'(k), 1'b0, STATE_ERROR, 12'hC05, "sat");
        check("sat_fe", 32'(err_count), 32'hFE);
        send(2'b11, 8'hA5, 1'b0, STATE_ERROR, 12'hC05, "sat_last");
        check("sat_ff", 32'(err_count), 32'hFF);
        send(2'b00, 8'h5A, 1'b0, STATE_ERROR, 12'hC05, "sat_over1");
        send(2'b11, 8'h00, 1'b0, STATE_ERROR, 12'hC05, "sat_over2");
        check("sat_hold", 32'(err_count), 32'hFF);
        send(2'b01, 8'h00, 1'b0, STATE_READ, 12'hA00, "read_sat");
        check("read_sat_err", 32'(err_count), 32'hFF);

        // Reset during bit 6 of a write frame.
        in_valid = 1'b1; in_cmd = 2'b10; in_data = 8'hFF;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("mid_frame", 32'(tx_frame), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_frame", 32'(tx_frame), 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd1);
        check("mrst_state", 32'(out_state), 32'(STATE_IDLE));
        check("mrst_err", 32'(err_count), 32'd0);
        tick();
        check("mrst_quiet", 32'(tx_frame), 32'd0);
        send(2'b01, 8'h5A, 1'b0, STATE_READ, 12'hA5A, "post_rst");

        // GAP_CYCLES=0 with in_valid held high.
        last = -1; nacc = 0; bad = 0; got = '0;
        v0 = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c >= 1 && c <= 12) got[12-c] = b0;
            if (r0 && f0) bad++;
            if (r0) begin
                if (last >= 0) check("b2b_gap", 32'(c - last), 32'd13);
                last = c;
                nacc++;
            end
            tick();
        end
        v0 = 1'b0;
        check("b2b_count", 32'(nacc), 32'd5);
        check("b2b_overlap", 32'(bad), 32'd0);
        check("b2b_pkt", 32'(got), 32'hA3C);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
